// File: rtl/sqrt_engine.sv
`default_nettype none
// ============================================================================
// Module      : sqrt_engine
// Description : Integer square root of an unsigned WIDTH-bit radicand using
//               the restoring digit-by-digit method (two radicand bits per
//               step, one root bit per clock). Produces floor(sqrt(x)) and
//               the remainder x - root^2 with a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module sqrt_engine #(
    parameter int WIDTH  = 8,
    parameter int ROOT_W = WIDTH / 2
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  radicand,
    output logic              busy,
    output logic              done,
    output logic [ROOT_W-1:0] root,
    output logic [ROOT_W:0]   rem
);

    localparam int c_cnt_w = $clog2(ROOT_W + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(ROOT_W);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // Reject unsupported or inconsistent widths at elaboration time.
    generate
        if ((WIDTH % 2 != 0) || (WIDTH < 4) || (WIDTH > 64) || (ROOT_W != WIDTH / 2)) begin : g_bad_width
            $error("sqrt_engine: WIDTH must be even in 4..64 and ROOT_W must equal WIDTH/2");
        end
    endgenerate

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [WIDTH-1:0]   r_x;
    logic [ROOT_W-1:0]  r_r;
    // Working remainder never exceeds 2*R of a partial root, so ROOT_W bits
    // hold it between iterations; only the final step needs ROOT_W+1 bits.
    logic [ROOT_W-1:0]  r_p;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ROOT_W-1:0]  r_root;
    logic [ROOT_W:0]    r_rem;

    logic [1:0]         w_x_top;
    logic [ROOT_W+1:0]  w_trial;
    logic               w_neg;
    logic [ROOT_W:0]    w_p_next;
    logic [ROOT_W-1:0]  w_r_next;
    logic               w_accept;
    logic               w_last;

    // One restoring iteration: trial-subtract {R,01} from {P,next two bits}.
    // The trial difference always fits ROOT_W+2 signed bits, so its MSB is
    // a reliable sign.
    assign w_x_top  = r_x[WIDTH-1 -: 2];
    assign w_trial  = {r_p, w_x_top} - {r_r, 2'b01};
    assign w_neg    = w_trial[ROOT_W+1];
    assign w_p_next = w_neg ? {r_p[ROOT_W-2:0], w_x_top} : w_trial[ROOT_W:0];
    assign w_r_next = {r_r[ROOT_W-2:0], ~w_neg};

    assign w_accept = start && (r_state != c_st_calc);
    assign w_last   = (r_state == c_st_calc) && (r_cnt == c_cnt_one);

    assign busy = (r_state == c_st_calc);
    assign done = (r_state == c_st_done);
    assign root = r_root;
    assign rem  = r_rem;

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured outside CALC.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_next = c_st_calc;
                end
            end
            c_st_calc: begin
                if (w_last) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: begin
                w_state_next = start ? c_st_calc : c_st_idle;
            end
            default: begin
                w_state_next = c_st_idle;
            end
        endcase
    end

    // Datapath: capture on accept, iterate in CALC, publish on the last step.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_x    <= '0;
            r_r    <= '0;
            r_p    <= '0;
            r_cnt  <= '0;
            r_root <= '0;
            r_rem  <= '0;
        end else if (w_accept) begin
            r_x   <= radicand;
            r_r   <= '0;
            r_p   <= '0;
            r_cnt <= c_cnt_init;
        end else if (r_state == c_st_calc) begin
            r_x   <= {r_x[WIDTH-3:0], 2'b00};
            r_r   <= w_r_next;
            r_p   <= w_p_next[ROOT_W-1:0];
            r_cnt <= r_cnt - c_cnt_one;
            if (w_last) begin
                r_root <= w_r_next;
                r_rem  <= w_p_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sqrt_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_sqrt_engine
// Description : Self-checking bench for sqrt_engine at WIDTH=8 and WIDTH=16.
//               A transaction-level model predicts busy/done/root/rem each
//               cycle; directed tests pin literal results and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sqrt_engine;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        start8, start16;
    logic [7:0]  rad8;
    logic [15:0] rad16;
    logic        busy8, done8, busy16, done16;
    logic [3:0]  root8;
    logic [4:0]  rem8;
    logic [7:0]  root16;
    logic [8:0]  rem16;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sqrt_engine #(.WIDTH(8)) dut8 (
        .clk(clk), .clr_n(clr_n), .start(start8), .radicand(rad8),
        .busy(busy8), .done(done8), .root(root8), .rem(rem8)
    );

    sqrt_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .clr_n(clr_n), .start(start16), .radicand(rad16),
        .busy(busy16), .done(done16), .root(root16), .rem(rem16)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned v);
        longint unsigned r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Transaction model: a request is accepted whenever the unit has no
    // job in flight; its result appears exactly ROOT_W edges later.
    // ------------------------------------------------------------------
    int              cyc = 0;
    bit              m_inflight [2];
    bit              m_done     [2];
    int              m_due      [2];
    longint unsigned m_rad      [2];
    longint unsigned m_root     [2];
    longint unsigned m_rem      [2];

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < 2; k++) begin
                m_inflight[k] <= 1'b0;
                m_done[k]     <= 1'b0;
                m_root[k]     <= 0;
                m_rem[k]      <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= 1'b0;
                if (m_inflight[k]) begin
                    if (cyc + 1 == m_due[k]) begin
                        m_inflight[k] <= 1'b0;
                        m_done[k]     <= 1'b1;
                        m_root[k]     <= isqrt(m_rad[k]);
                        m_rem[k]      <= m_rad[k] - isqrt(m_rad[k]) * isqrt(m_rad[k]);
                    end
                end else if ((k == 0) ? start8 : start16) begin
                    m_inflight[k] <= 1'b1;
                    m_rad[k]      <= (k == 0) ? longint'(rad8) : longint'(rad16);
                    m_due[k]      <= cyc + 1 + ((k == 0) ? 4 : 8);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        check("busy8",  busy8,  m_inflight[0]);
        check("done8",  done8,  m_done[0]);
        check("root8",  root8,  m_root[0]);
        check("rem8",   rem8,   m_rem[0]);
        check("busy16", busy16, m_inflight[1]);
        check("done16", done16, m_done[1]);
        check("root16", root16, m_root[1]);
        check("rem16",  rem16,  m_rem[1]);
        if (done8) begin
            check("prop8_sum", root8 * root8 + rem8, m_rad[0]);
            check("prop8_rem_le_2root", rem8 <= 2 * root8, 1);
        end
        if (done16) begin
            check("prop16_sum", root16 * root16 + rem16, m_rad[1]);
            check("prop16_rem_le_2root", rem16 <= 2 * root16, 1);
        end
    end

    // Pulse start for one accepting edge; returns the cycle index of that edge.
    task automatic go(input int k, input logic [15:0] v, output int e0);
        if (k == 0) begin start8 = 1'b1; rad8 = v[7:0]; end
        else        begin start16 = 1'b1; rad16 = v; end
        @(posedge clk); #1;
        e0 = cyc;
        // Scramble the operand while busy; it must not matter.
        if (k == 0) begin start8 = 1'b0; rad8 = 8'($urandom); end
        else        begin start16 = 1'b0; rad16 = 16'($urandom); end
    endtask

    // Wait (bounded) for the done pulse; returns the cycle it was seen in.
    task automatic wait_done(input int k, output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (((k == 0) ? done8 : done16) === 1'b1) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout_done%0d: got no done expected done within 40 cycles", k);
        end
    endtask

    task automatic run8(input logic [7:0] v, input int er, input int erem);
        int e0, c;
        go(0, {8'd0, v}, e0);
        wait_done(0, c);
        check("lat8", c - e0, 4);
        check("lit_root8", root8, er);
        check("lit_rem8", rem8, erem);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before 5ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int e0, c, pulses;
        clr_n = 1'b0; start8 = 1'b0; start16 = 1'b0; rad8 = '0; rad16 = '0;

        // Model pins.
        check("model_isqrt_144", isqrt(144), 12);
        check("model_isqrt_99", isqrt(99), 9);
        check("model_isqrt_65535", isqrt(65535), 255);
        check("model_isqrt_200", isqrt(200), 14);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", busy8, 0);
        check("rst_done8", done8, 0);
        check("rst_root8", root8, 0);
        check("rst_rem8", rem8, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        @(posedge clk); #1;

        // Basic and boundary 8-bit results.
        run8(8'd144, 12, 0);
        run8(8'd0, 0, 0);
        run8(8'd99, 9, 18);
        run8(8'd255, 15, 30);

        // A second start during CALC is ignored.
        go(0, 16'd99, e0);
        @(posedge clk); #1;
        start8 = 1'b1; rad8 = 8'd16;
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(0, c);
        check("ign_lat8", c - e0, 4);
        check("ign_root8", root8, 9);
        check("ign_rem8", rem8, 18);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("ign_extra_done", pulses, 0);

        // Back-to-back with start held high.
        @(posedge clk); #1;
        start8 = 1'b1; rad8 = 8'd200;
        @(posedge clk); #1;
        e0 = cyc;
        rad8 = 8'd50;
        wait_done(0, c);
        check("b2b_lat_a", c - e0, 4);
        check("b2b_root_a", root8, 14);
        check("b2b_rem_a", rem8, 4);
        @(posedge clk); #1;
        start8 = 1'b0;
        wait_done(0, c);
        check("b2b_lat_b", c - e0, 9);
        check("b2b_root_b", root8, 7);
        check("b2b_rem_b", rem8, 1);
        @(posedge clk); #1;

        // Asynchronous reset two cycles into CALC.
        go(0, 16'd99, e0);
        @(posedge clk); #1;
        clr_n = 1'b0;
        #1;
        check("arst_busy8", busy8, 0);
        check("arst_done8", done8, 0);
        check("arst_root8", root8, 0);
        check("arst_rem8", rem8, 0);
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("arst_no_done", pulses, 0);
        @(posedge clk); #1;
        run8(8'd81, 9, 0);

        // WIDTH=16 boundaries and random sweep.
        go(1, 16'd0, e0);
        wait_done(1, c);
        check("lat16_zero", c - e0, 8);
        check("root16_zero", root16, 0);
        check("rem16_zero", rem16, 0);
        @(posedge clk); #1;
        go(1, 16'hFFFF, e0);
        wait_done(1, c);
        check("lat16_max", c - e0, 8);
        check("root16_max", root16, 255);
        check("rem16_max", rem16, 510);
        @(posedge clk); #1;
        for (int n = 0; n < 1000; n++) begin
            go(1, 16'($urandom_range(0, 65535)), e0);
            wait_done(1, c);
            check("lat16_rand", c - e0, 8);
            @(posedge clk); #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sqrt_engine.md
Name: sqrt_engine

Overview:
- Self-contained, parametrised integer square-root unit with an integrated controller and datapath.
- Computes floor(sqrt(radicand)) and the remainder for a WIDTH-bit unsigned radicand.
- Uses the digit-by-digit (restoring, radix-4) method: one result bit per clock, fixed latency.
- Sits between the input register/switch logic and the display/output stage; exposes a start/busy/done handshake so upstream logic can issue back-to-back requests.

Parameters:
- WIDTH, 8, radicand width in bits; must be even, 4..64; odd values are an elaboration error.
- ROOT_W, WIDTH/2, root width (derived; do not override).

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- clr_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on rising clk edges while not busy.
- radicand  input  WIDTH  unsigned operand; captured on the accepting edge only.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse: root/rem are valid.
- root  output  ROOT_W  floor(sqrt(radicand)).
- rem  output  ROOT_W+1  radicand - root*root; range 0..2*root.

Behaviour:
- Reset (clr_n=0, any time, asynchronous): state=IDLE; busy=0, done=0, root=0, rem=0; iteration counter=0; captured operand=0. Reset mid-computation abandons it; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE: busy=0, done=0. On an edge with start=1:
  - capture radicand into shift register X;
  - clear working root R and remainder P;
  - set count=ROOT_W;
  - go to CALC.
- CALC: busy=1. Each edge performs one iteration:
  - T = {P, X[WIDTH-1:WIDTH-2]} - {R, 2'b01}, computed at ROOT_W+2 bits;
  - if T >= 0: P = T, R = {R, 1};
  - else: P = {P, top two bits of X}, R = {R, 0};
  - shift X left by 2; decrement count;
  - on the edge where count goes 1 -> 0, go to DONE.
  - start is ignored in CALC: no restart, no queueing.
- DONE: busy=0, done=1 for exactly one cycle; root=R, rem=P[ROOT_W:0].
  - Next edge with start=0: go to IDLE.
  - Next edge with start=1: accept new radicand as in IDLE and go to CALC; done drops.
- Outputs root/rem hold their values from DONE until the next DONE pulse or reset. They do not update during CALC.
- Latency: start accepted at edge E0. busy is visible after E0. Results and done are visible after edge E0+ROOT_W. done falls after E0+ROOT_W+1.
- Throughput: one result per ROOT_W+1 cycles back-to-back (start held high continuously).
- Arithmetic:
  - all unsigned;
  - the subtraction sign is taken from the MSB of the ROOT_W+2-bit result;
  - no overflow is possible;
  - rem never exceeds 2*root.
- Boundaries:
  - radicand=0 gives root=0, rem=0.
  - radicand=2^WIDTH-1 gives root=2^ROOT_W-1, rem=2^(ROOT_W+1)-2.
  - radicand changing during CALC has no effect.
  - start and reset deassertion in the same cycle: reset wins for that cycle; start is sampled only on a later edge.

Test Plan:
- WIDTH=8, reset then start with radicand=144 -> busy for 4 cycles; done pulses once at E0+4; root=12, rem=0.
- WIDTH=8, radicand=0 / 99 / 255 -> root, rem = 0,0 / 9,18 / 15,30.
  - Checker compares every sample with root*root+rem==radicand and rem<=2*root.
- WIDTH=8, start pulsed again 2 cycles into CALC with radicand=16 -> ignored; first result (radicand=99) returns 9,18 on schedule; no extra done.
- start held high, radicands 200 then 50 presented on successive accepting edges:
  - done pulses at E0+4 and E0+9;
  - results 14,4 then 7,1;
  - busy low only during the DONE cycles.
- clr_n driven low 2 cycles into CALC -> all outputs 0 immediately (asynchronous); no done pulse. The next start with radicand=81 gives 9,0.
- WIDTH=16, random sweep of 1000 radicands plus 0 and 65535 -> 65535 gives 255,510; every result is correct; latency is exactly 8 cycles.
